reg_bank_88: RTL and testbench



---
 rtl/eclair_pkg.sv | 23 ++
 rtl/reg_bank_88_inc_dec_16.sv | 29 ++
 rtl/reg_bank_88.sv | 89 ++++++++
 tb/tb_reg_bank_88.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/eclair_pkg.sv
// Shared encodings for the register bank: op codes, register indices, data width.
// Pure declarations; no timing or flow-control behaviour lives here.
package eclair_pkg;

  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    OP_NOP  = 2'b00,
    OP_LOAD = 2'b01,
    OP_INC  = 2'b10,
    OP_DEC  = 2'b11
  } op_e;

  localparam logic [2:0] REG_A = 3'd0;
  localparam logic [2:0] REG_B = 3'd1;
  localparam logic [2:0] REG_C = 3'd2;
  localparam logic [2:0] REG_D = 3'd3;
  localparam logic [2:0] REG_E = 3'd4;
  localparam logic [2:0] REG_F = 3'd5;
  localparam logic [2:0] REG_G = 3'd6;
  localparam logic [2:0] REG_H = 3'd7;

endpackage

// File: rtl/reg_bank_88_inc_dec_16.sv
// Combinational +/-1 on an 8-bit byte or a 16-bit pair, with carry/borrow and zero.
// Zero latency, no flow control; high byte passes through untouched in byte mode.
module inc_dec_16 (
  input  logic [15:0] operand,
  input  logic        dec,
  input  logic        pair,
  output logic [15:0] result,
  output logic        carry,
  output logic        zero
);

  logic [16:0] wide;
  logic [8:0]  narrow;

  // The extra top bit of each sum is the carry (inc) or borrow (dec).
  always_comb begin
    wide   = dec ? ({1'b0, operand} - 17'd1) : ({1'b0, operand} + 17'd1);
    narrow = dec ? ({1'b0, operand[7:0]} - 9'd1) : ({1'b0, operand[7:0]} + 9'd1);
    result = {operand[15:8], narrow[7:0]};
    carry  = narrow[8];
    zero   = (narrow[7:0] == 8'd0);
    if (pair) begin
      result = wide[15:0];
      carry  = wide[16];
      zero   = (wide[15:0] == 16'd0);
    end
  end

endmodule

// File: rtl/reg_bank_88.sv
// Eight 8-bit registers with one load/inc/dec port (byte or even/odd pair), flags and done pulse.
// Op sampled on edge N, results visible after edge N; accepts one op every cycle, never stalls.
module reg_bank_88
  import eclair_pkg::*;
#(
  parameter logic [DATA_W-1:0] RESET_VAL    = 8'h00,
  parameter bit                FLAG_ON_LOAD = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        op,
  input  logic [2:0]        wsel,
  input  logic              pair,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] a,
  output logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] c,
  output logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] e,
  output logic [DATA_W-1:0] f,
  output logic [DATA_W-1:0] g,
  output logic [DATA_W-1:0] h,
  output logic              zero,
  output logic              carry,
  output logic              done
);

  logic [DATA_W-1:0] regs [8];
  op_e               opc;
  logic [2:0]        lo_idx;
  logic [2:0]        hi_idx;
  logic [15:0]       operand;
  logic [15:0]       res;
  logic              res_carry;
  logic              res_zero;

  assign opc = op_e'(op);

  // In byte mode the low index is the target itself, so one write path serves both modes.
  assign lo_idx  = pair ? {wsel[2:1], 1'b0} : wsel;
  assign hi_idx  = {wsel[2:1], 1'b1};
  assign operand = {regs[hi_idx], regs[lo_idx]};

  inc_dec_16 u_inc_dec (
    .operand (operand),
    .dec     (opc == OP_DEC),
    .pair    (pair),
    .result  (res),
    .carry   (res_carry),
    .zero    (res_zero)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) regs[i] <= RESET_VAL;
      zero  <= 1'b0;
      carry <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= (opc != OP_NOP);
      case (opc)
        OP_LOAD: begin
          regs[wsel] <= din;
          if (FLAG_ON_LOAD) begin
            zero  <= (din == '0);
            carry <= 1'b0;
          end
        end
        OP_INC, OP_DEC: begin
          regs[lo_idx] <= res[7:0];
          if (pair) regs[hi_idx] <= res[15:8];
          zero  <= res_zero;
          carry <= res_carry;
        end
        default: ;
      endcase
    end
  end

  assign a = regs[REG_A];
  assign b = regs[REG_B];
  assign c = regs[REG_C];
  assign d = regs[REG_D];
  assign e = regs[REG_E];
  assign f = regs[REG_F];
  assign g = regs[REG_G];
  assign h = regs[REG_H];

endmodule

// File: tb/tb_reg_bank_88.sv
// Drives two banks (flags-on-load off and on) with directed and random ops against an arithmetic model.
module tb_reg_bank_88;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] op;
  logic [2:0] wsel;
  logic       pair;
  logic [7:0] din;

  logic [7:0] r0 [8];
  logic [7:0] r1 [8];
  logic       z0, c0, dn0, z1, c1, dn1;

  int ncmp  = 0;
  int nfail = 0;

  // Reference model: index 0 = FLAG_ON_LOAD 0, index 1 = FLAG_ON_LOAD 1
  int m_reg   [2][8];
  int m_zero  [2];
  int m_carry [2];
  int m_done;

  always #5 clk = ~clk;

  reg_bank_88 #(.RESET_VAL(8'h00), .FLAG_ON_LOAD(1'b0)) dut0 (
    .clk(clk), .reset(reset), .op(op), .wsel(wsel), .pair(pair), .din(din),
    .a(r0[0]), .b(r0[1]), .c(r0[2]), .d(r0[3]), .e(r0[4]), .f(r0[5]), .g(r0[6]), .h(r0[7]),
    .zero(z0), .carry(c0), .done(dn0)
  );

  reg_bank_88 #(.RESET_VAL(8'h00), .FLAG_ON_LOAD(1'b1)) dut1 (
    .clk(clk), .reset(reset), .op(op), .wsel(wsel), .pair(pair), .din(din),
    .a(r1[0]), .b(r1[1]), .c(r1[2]), .d(r1[3]), .e(r1[4]), .f(r1[5]), .g(r1[6]), .h(r1[7]),
    .zero(z1), .carry(c1), .done(dn1)
  );

  function automatic logic [66:0] dut_vec(int k);
    logic [66:0] v;
    v = '0;
    for (int i = 0; i < 8; i++) v[66-8*i -: 8] = (k == 0) ? r0[i] : r1[i];
    v[2] = (k == 0) ? z0 : z1;
    v[1] = (k == 0) ? c0 : c1;
    v[0] = (k == 0) ? dn0 : dn1;
    return v;
  endfunction

  function automatic logic [66:0] mdl_vec(int k);
    logic [66:0] v;
    v = '0;
    for (int i = 0; i < 8; i++) v[66-8*i -: 8] = 8'(m_reg[k][i]);
    v[2] = (m_zero[k] != 0);
    v[1] = (m_carry[k] != 0);
    v[0] = (m_done != 0);
    return v;
  endfunction

  task automatic model_step(int o, int w, int p, int dv, int rst);
    int lo, hi, v, nv, modulus;
    if (rst != 0) begin
      for (int k = 0; k < 2; k++) begin
        for (int i = 0; i < 8; i++) m_reg[k][i] = 0;
        m_zero[k] = 0;
        m_carry[k] = 0;
      end
      m_done = 0;
      return;
    end
    m_done = (o != 0) ? 1 : 0;
    for (int k = 0; k < 2; k++) begin
      if (o == 1) begin
        m_reg[k][w] = dv;
        if (k == 1) begin
          m_zero[k] = (dv == 0) ? 1 : 0;
          m_carry[k] = 0;
        end
      end else if (o == 2 || o == 3) begin
        lo = (p != 0) ? (w & 6) : w;
        hi = w | 1;
        modulus = (p != 0) ? 65536 : 256;
        v = (p != 0) ? m_reg[k][hi] * 256 + m_reg[k][lo] : m_reg[k][lo];
        if (o == 2) begin
          m_carry[k] = (v == modulus - 1) ? 1 : 0;
          nv = (v + 1) % modulus;
        end else begin
          m_carry[k] = (v == 0) ? 1 : 0;
          nv = (v + modulus - 1) % modulus;
        end
        m_zero[k] = (nv == 0) ? 1 : 0;
        m_reg[k][lo] = nv % 256;
        if (p != 0) m_reg[k][hi] = nv / 256;
      end
    end
  endtask

  // Present one op at the falling edge, let it be sampled, return at the next falling edge.
  task automatic step(int o, int w, int p, int dv, int rst);
    reset = (rst != 0);
    op    = 2'(o);
    wsel  = 3'(w);
    pair  = (p != 0);
    din   = 8'(dv);
    @(posedge clk);
    model_step(o, w, p, dv, rst);
    @(negedge clk);
  endtask

  task automatic test_reset();
    step(0, 0, 0, 0, 1);
    step(1, 3, 0, 8'h55, 1);
    ncmp++;
    if (r0[3] !== 8'h00 || r1[3] !== 8'h00) begin
      nfail++;
      $display("FAIL reset_d got %h/%h want 00", r0[3], r1[3]);
    end
    for (int k = 0; k < 2; k++) begin
      ncmp++;
      if (dut_vec(k) !== mdl_vec(k)) begin
        nfail++;
        $display("FAIL reset_state dut%0d got %h want %h", k, dut_vec(k), mdl_vec(k));
      end
    end
  endtask

  task automatic test_inc_wrap();
    step(1, 2, 0, 8'hFF, 0);
    ncmp++;
    if (r0[2] !== 8'hFF || dn0 !== 1'b1) begin
      nfail++;
      $display("FAIL load_c got c=%h done=%b want c=ff done=1", r0[2], dn0);
    end
    step(2, 2, 0, 0, 0);
    ncmp++;
    if ({r0[2], c0, z0, dn0} !== {8'h00, 1'b1, 1'b1, 1'b1}) begin
      nfail++;
      $display("FAIL inc_wrap got c=%h carry=%b zero=%b done=%b want 00 1 1 1", r0[2], c0, z0, dn0);
    end
    ncmp++;
    if (dut_vec(0) !== mdl_vec(0)) begin
      nfail++;
      $display("FAIL inc_wrap_others got %h want %h", dut_vec(0), mdl_vec(0));
    end
  endtask

  task automatic test_dec_borrow();
    step(2'd3, 5, 0, 0, 0);
    ncmp++;
    if ({r0[5], c0, z0} !== {8'hFF, 1'b1, 1'b0}) begin
      nfail++;
      $display("FAIL dec_borrow got f=%h carry=%b zero=%b want ff 1 0", r0[5], c0, z0);
    end
  endtask

  task automatic test_pair();
    step(1, 4, 0, 8'hFF, 0);
    step(1, 5, 1, 8'h00, 0);
    step(2, 5, 1, 0, 0);
    ncmp++;
    if ({r0[5], r0[4], c0, z0} !== {16'h0100, 1'b0, 1'b0}) begin
      nfail++;
      $display("FAIL pair_inc got fe=%h%h carry=%b zero=%b want 0100 0 0", r0[5], r0[4], c0, z0);
    end
    step(1, 4, 0, 8'hFF, 0);
    step(1, 5, 0, 8'hFF, 0);
    step(2, 4, 1, 0, 0);
    ncmp++;
    if ({r0[5], r0[4], c0, z0} !== {16'h0000, 1'b1, 1'b1}) begin
      nfail++;
      $display("FAIL pair_wrap got fe=%h%h carry=%b zero=%b want 0000 1 1", r0[5], r0[4], c0, z0);
    end
    step(2'd3, 5, 1, 0, 0);
    ncmp++;
    if ({r0[5], r0[4], c0, z0} !== {16'hFFFF, 1'b1, 1'b0}) begin
      nfail++;
      $display("FAIL pair_dec got fe=%h%h carry=%b zero=%b want ffff 1 0", r0[5], r0[4], c0, z0);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] want [3];
    want[0] = 8'h7F;
    want[1] = 8'h80;
    want[2] = 8'h7F;
    step(1, 1, 0, 8'h7E, 0);
    for (int i = 0; i < 3; i++) begin
      step((i == 2) ? 3 : 2, 1, 0, 0, 0);
      ncmp++;
      if (r0[1] !== want[i] || dn0 !== 1'b1) begin
        nfail++;
        $display("FAIL b2b_%0d got b=%h done=%b want %h 1", i, r0[1], dn0, want[i]);
      end
    end
    ncmp++;
    if ({z0, c0} !== 2'b00) begin
      nfail++;
      $display("FAIL b2b_flags got zero=%b carry=%b want 0 0", z0, c0);
    end
  endtask

  task automatic test_load_flags();
    step(1, 2, 0, 8'hFF, 0);
    step(2, 2, 0, 0, 0);
    step(1, 6, 0, 8'hAA, 0);
    ncmp++;
    if ({z0, c0, z1, c1} !== 4'b1100) begin
      nfail++;
      $display("FAIL load_aa_flags got z0=%b c0=%b z1=%b c1=%b want 1 1 0 0", z0, c0, z1, c1);
    end
    step(1, 6, 0, 8'h00, 0);
    ncmp++;
    if ({r1[6], z1, c1} !== {8'h00, 1'b1, 1'b0}) begin
      nfail++;
      $display("FAIL load_00_flags got g=%h zero=%b carry=%b want 00 1 0", r1[6], z1, c1);
    end
    step(0, 6, 0, 8'h33, 0);
    ncmp++;
    if ({dn0, dn1, z0, c0, z1, c1, r0[6]} !== {6'b001110, 8'h00}) begin
      nfail++;
      $display("FAIL nop_hold got done=%b%b z0=%b c0=%b z1=%b c1=%b g=%h want 00 1 1 1 0 00",
               dn0, dn1, z0, c0, z1, c1, r0[6]);
    end
  endtask

  task automatic test_random();
    int o, w, p, dv, rst;
    for (int n = 0; n < 400; n++) begin
      o   = $urandom_range(3, 0);
      w   = $urandom_range(7, 0);
      p   = $urandom_range(1, 0);
      dv  = ($urandom_range(3, 0) == 0) ? 8'hFF * $urandom_range(1, 0) : $urandom_range(255, 0);
      rst = ($urandom_range(39, 0) == 0) ? 1 : 0;
      step(o, w, p, dv, rst);
      for (int k = 0; k < 2; k++) begin
        ncmp++;
        if (dut_vec(k) !== mdl_vec(k)) begin
          nfail++;
          $display("FAIL random_%0d dut%0d op=%0d w=%0d p=%0d got %h want %h",
                   n, k, o, w, p, dut_vec(k), mdl_vec(k));
        end
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    op    = 2'd0;
    wsel  = 3'd0;
    pair  = 1'b0;
    din   = 8'd0;
    @(negedge clk);
    test_reset();
    test_inc_wrap();
    test_dec_borrow();
    test_pair();
    test_back_to_back();
    test_load_flags();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
